// File: rtl/mem_stage_sram_ctrl_pkg.sv
// Shared state encoding, defaults and helpers for the memory-stage SRAM controller.
// The optional stall counter is enabled with the MEM_STALL_CNT_EN macro in the top module.
package mem_stage_sram_ctrl_pkg;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_LO   = 2'd1,
        ST_HI   = 2'd2,
        ST_DONE = 2'd3
    } state_e;

    localparam int DEFAULT_WAIT_CYCLES = 2;
    localparam int DEFAULT_BASE_ADDR   = 1024;
    localparam int DEFAULT_SRAM_AW     = 18;
    localparam int WAIT_CNT_W          = 4;

    // Terminal value of the per-phase wait counter for a given wait-state setting.
    function automatic logic [WAIT_CNT_W-1:0] last_wait_count(input int wait_cycles);
        return WAIT_CNT_W'(wait_cycles - 1);
    endfunction

endpackage

// File: rtl/mem_stage_sram_ctrl_sram_addr_map.sv
// Maps a pipeline byte address onto the low/high SRAM halfword addresses of its 32-bit word.
module mem_stage_sram_ctrl_sram_addr_map
    import mem_stage_sram_ctrl_pkg::*;
#(
    parameter int BASE_ADDR = DEFAULT_BASE_ADDR,
    parameter int SRAM_AW   = DEFAULT_SRAM_AW
) (
    input  logic [31:0]        byte_addr_i,
    output logic [SRAM_AW-1:0] lo_addr_o,
    output logic [SRAM_AW-1:0] hi_addr_o
);

    localparam int          WORD_AW = SRAM_AW - 1;
    localparam logic [31:0] BASE    = 32'(BASE_ADDR);

    logic [WORD_AW-1:0] word_addr;

    // Plain modulo arithmetic: addresses below BASE wrap to the top of the SRAM.
    assign word_addr = WORD_AW'((byte_addr_i - BASE) >> 2);

    assign lo_addr_o = {word_addr, 1'b0};
    assign hi_addr_o = {word_addr, 1'b1};

endmodule

// File: rtl/mem_stage_sram_ctrl.sv
// Memory stage: runs each 32-bit load/store as two 16-bit SRAM phases and freezes the pipeline.
// Define MEM_STALL_CNT_EN to add the saturating stall_cnt output.
module mem_stage_sram_ctrl
    import mem_stage_sram_ctrl_pkg::*;
#(
    parameter int WAIT_CYCLES = DEFAULT_WAIT_CYCLES,
    parameter int BASE_ADDR   = DEFAULT_BASE_ADDR,
    parameter int SRAM_AW     = DEFAULT_SRAM_AW
) (
    input  logic               clk,
    input  logic               rst,
    input  logic               WB_en_in,
    input  logic               MEM_R_EN_in,
    input  logic               MEM_W_EN_in,
    input  logic [31:0]        ALU_result_in,
    input  logic [31:0]        ST_val_in,
    input  logic [3:0]         Dest_in,
    output logic               WB_en,
    output logic               MEM_R_EN,
    output logic [31:0]        ALU_result,
    output logic [31:0]        Mem_read_value,
    output logic [3:0]         Dest,
    output logic               freeze,
    output logic [SRAM_AW-1:0] SRAM_ADDR,
    output logic [15:0]        SRAM_DQ_out,
    input  logic [15:0]        SRAM_DQ_in,
`ifdef MEM_STALL_CNT_EN
    output logic [31:0]        stall_cnt,
`endif
    output logic               SRAM_WE_N
);

    localparam logic [WAIT_CNT_W-1:0] LAST_CNT = last_wait_count(WAIT_CYCLES);

    state_e                  state_q;
    logic [WAIT_CNT_W-1:0]   cnt_q;
    logic [31:0]             rd_data_q;
    logic [SRAM_AW-1:0]      sram_addr_q;
    logic [15:0]             sram_dq_q;
    logic                    sram_we_n_q;

    logic [SRAM_AW-1:0]      lo_addr;
    logic [SRAM_AW-1:0]      hi_addr;
    logic                    req;
    logic                    is_load;
    logic                    phase_end;

    assign req       = MEM_R_EN_in | MEM_W_EN_in;
    // A write wins when both enables are set, so the load register is left alone.
    assign is_load   = MEM_R_EN_in & ~MEM_W_EN_in;
    assign phase_end = (cnt_q == LAST_CNT);

    // NOTE: gated by rst so a request still held by the pipeline cannot freeze it during reset.
    assign freeze = rst & req & (state_q != ST_DONE);

    assign WB_en          = WB_en_in & ~freeze;
    assign MEM_R_EN       = MEM_R_EN_in & ~freeze;
    assign ALU_result     = ALU_result_in;
    assign Dest           = Dest_in;
    assign Mem_read_value = rd_data_q;
    assign SRAM_ADDR      = sram_addr_q;
    assign SRAM_DQ_out    = sram_dq_q;
    assign SRAM_WE_N      = sram_we_n_q;

    mem_stage_sram_ctrl_sram_addr_map #(
        .BASE_ADDR (BASE_ADDR),
        .SRAM_AW   (SRAM_AW)
    ) u_addr_map (
        .byte_addr_i (ALU_result_in),
        .lo_addr_o   (lo_addr),
        .hi_addr_o   (hi_addr)
    );

    // SRAM pins are loaded on the edge that enters a phase, so they line up with state_q.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q     <= ST_IDLE;
            cnt_q       <= '0;
            rd_data_q   <= '0;
            sram_addr_q <= '0;
            sram_dq_q   <= '0;
            sram_we_n_q <= 1'b1;
        end else begin
            // NOTE: non-blocking only; every branch below must see the pre-edge values.
            unique case (state_q)
                ST_IDLE: begin
                    if (req) begin
                        state_q     <= ST_LO;
                        cnt_q       <= '0;
                        sram_addr_q <= lo_addr;
                        sram_dq_q   <= ST_val_in[15:0];
                        sram_we_n_q <= ~MEM_W_EN_in;
                    end
                end
                ST_LO: begin
                    if (phase_end) begin
                        if (is_load) begin
                            rd_data_q[15:0] <= SRAM_DQ_in;
                        end
                        state_q     <= ST_HI;
                        cnt_q       <= '0;
                        sram_addr_q <= hi_addr;
                        sram_dq_q   <= ST_val_in[31:16];
                        sram_we_n_q <= ~MEM_W_EN_in;
                    end else begin
                        cnt_q <= cnt_q + 4'd1;
                    end
                end
                ST_HI: begin
                    if (phase_end) begin
                        if (is_load) begin
                            rd_data_q[31:16] <= SRAM_DQ_in;
                        end
                        state_q     <= ST_DONE;
                        cnt_q       <= '0;
                        sram_we_n_q <= 1'b1;
                    end else begin
                        cnt_q <= cnt_q + 4'd1;
                    end
                end
                ST_DONE: begin
                    state_q <= ST_IDLE;
                end
                default: begin
                    state_q     <= ST_IDLE;
                    cnt_q       <= '0;
                    sram_we_n_q <= 1'b1;
                end
            endcase
        end
    end

`ifdef MEM_STALL_CNT_EN
    logic [31:0] stall_cnt_q;
    logic [31:0] stall_cnt_d;

    // NOTE: default assignment first so the combinational block never infers a latch.
    always_comb begin
        stall_cnt_d = stall_cnt_q;
        if (freeze && (stall_cnt_q != 32'hFFFF_FFFF)) begin
            stall_cnt_d = stall_cnt_q + 32'd1;
        end
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            stall_cnt_q <= '0;
        end else begin
            stall_cnt_q <= stall_cnt_d;
        end
    end

    assign stall_cnt = stall_cnt_q;
`endif

endmodule

// File: tb/tb_mem_stage_sram_ctrl.sv
// Directed bench: two controllers (WAIT_CYCLES=2 and 1) with behavioural SRAMs, table-driven
// transactions plus hand-written reset-abort sequence. Checks stall_cnt when MEM_STALL_CNT_EN is set.
module tb_mem_stage_sram_ctrl;

    localparam int AW = 18;

    typedef struct {
        bit          sel;
        bit          wb;
        bit          r;
        bit          w;
        logic [31:0] alu;
        logic [31:0] st;
        logic [3:0]  dest;
        int          exp_frz;
        logic [17:0] exp_hw;
        bit          exp_wb;
        bit          exp_ren;
        logic [31:0] exp_rd;
    } vec_t;

    logic        clk;
    logic        rst;
    logic        sel;
    logic        wb_in, r_in, w_in;
    logic [31:0] alu_in, st_in;
    logic [3:0]  dest_in;
    logic        pl_en;
    logic [17:0] pl_addr;
    logic [15:0] pl_data;

    int total;
    int bad;

    logic a_r, a_w, b_r, b_w;
    assign a_r = r_in & ~sel;
    assign a_w = w_in & ~sel;
    assign b_r = r_in & sel;
    assign b_w = w_in & sel;

    logic          a_wb, a_ren, a_frz, a_we_n;
    logic [31:0]   a_alu, a_rd;
    logic [3:0]    a_dest;
    logic [AW-1:0] a_addr;
    logic [15:0]   a_dq_out, a_dq_in;
    logic          b_wb, b_ren, b_frz, b_we_n;
    logic [31:0]   b_alu, b_rd;
    logic [3:0]    b_dest;
    logic [AW-1:0] b_addr;
    logic [15:0]   b_dq_out, b_dq_in;
`ifdef MEM_STALL_CNT_EN
    logic [31:0]   a_stall, b_stall;
`endif

    mem_stage_sram_ctrl #(.WAIT_CYCLES(2), .BASE_ADDR(1024), .SRAM_AW(AW)) dut_a (
        .clk(clk), .rst(rst),
        .WB_en_in(wb_in), .MEM_R_EN_in(a_r), .MEM_W_EN_in(a_w),
        .ALU_result_in(alu_in), .ST_val_in(st_in), .Dest_in(dest_in),
        .WB_en(a_wb), .MEM_R_EN(a_ren), .ALU_result(a_alu), .Mem_read_value(a_rd),
        .Dest(a_dest), .freeze(a_frz), .SRAM_ADDR(a_addr), .SRAM_DQ_out(a_dq_out),
        .SRAM_DQ_in(a_dq_in),
`ifdef MEM_STALL_CNT_EN
        .stall_cnt(a_stall),
`endif
        .SRAM_WE_N(a_we_n)
    );

    mem_stage_sram_ctrl #(.WAIT_CYCLES(1), .BASE_ADDR(1024), .SRAM_AW(AW)) dut_b (
        .clk(clk), .rst(rst),
        .WB_en_in(wb_in), .MEM_R_EN_in(b_r), .MEM_W_EN_in(b_w),
        .ALU_result_in(alu_in), .ST_val_in(st_in), .Dest_in(dest_in),
        .WB_en(b_wb), .MEM_R_EN(b_ren), .ALU_result(b_alu), .Mem_read_value(b_rd),
        .Dest(b_dest), .freeze(b_frz), .SRAM_ADDR(b_addr), .SRAM_DQ_out(b_dq_out),
        .SRAM_DQ_in(b_dq_in),
`ifdef MEM_STALL_CNT_EN
        .stall_cnt(b_stall),
`endif
        .SRAM_WE_N(b_we_n)
    );

    // Behavioural SRAMs: asynchronous read, write on the clock edge while WE_N is low.
    logic [15:0] mem_a [0:(1<<AW)-1];
    logic [15:0] mem_b [0:(1<<AW)-1];
    assign a_dq_in = mem_a[a_addr];
    assign b_dq_in = mem_b[b_addr];

    always @(posedge clk) begin
        if (!a_we_n) mem_a[a_addr] <= a_dq_out;
        if (!b_we_n) mem_b[b_addr] <= b_dq_out;
        if (pl_en) begin
            mem_a[pl_addr] <= pl_data;
            mem_b[pl_addr] <= pl_data;
        end
    end

    logic          o_wb, o_ren, o_frz, o_we_n;
    logic [31:0]   o_alu, o_rd;
    logic [3:0]    o_dest;
    logic [AW-1:0] o_addr;
    logic [15:0]   o_dq;
    assign o_wb   = sel ? b_wb     : a_wb;
    assign o_ren  = sel ? b_ren    : a_ren;
    assign o_frz  = sel ? b_frz    : a_frz;
    assign o_we_n = sel ? b_we_n   : a_we_n;
    assign o_alu  = sel ? b_alu    : a_alu;
    assign o_rd   = sel ? b_rd     : a_rd;
    assign o_dest = sel ? b_dest   : a_dest;
    assign o_addr = sel ? b_addr   : a_addr;
    assign o_dq   = sel ? b_dq_out : a_dq_out;

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    initial begin
        #100000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog expired");
    end

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
        end
    endtask

    function automatic logic [31:0] mem_word(input logic [17:0] hw);
        if (sel) return {mem_b[hw + 18'd1], mem_b[hw]};
        return {mem_a[hw + 18'd1], mem_a[hw]};
    endfunction

    function automatic vec_t mk(input bit s, input bit wb, input bit r, input bit w,
                                input logic [31:0] alu, input logic [31:0] st,
                                input logic [3:0] dest, input int frz, input logic [17:0] hw,
                                input bit ewb, input bit eren, input logic [31:0] erd);
        vec_t v;
        v.sel = s; v.wb = wb; v.r = r; v.w = w;
        v.alu = alu; v.st = st; v.dest = dest;
        v.exp_frz = frz; v.exp_hw = hw;
        v.exp_wb = ewb; v.exp_ren = eren; v.exp_rd = erd;
        return v;
    endfunction

    task automatic preload(input logic [17:0] addr, input logic [15:0] data);
        pl_addr = addr;
        pl_data = data;
        pl_en   = 1'b1;
        @(posedge clk);
        #1 pl_en = 1'b0;
    endtask

    // Called just after a rising edge; returns just after the edge that ends the DONE cycle.
    task automatic run_vec(input vec_t v);
        int          n;
        bit          done;
        int          wc;
        logic [17:0] ehw;
        sel = v.sel; wb_in = v.wb; r_in = v.r; w_in = v.w;
        alu_in = v.alu; st_in = v.st; dest_in = v.dest;
        wc = v.sel ? 1 : 2;
        n = 0;
        done = 1'b0;
        for (int c = 0; c < 40 && !done; c++) begin
            @(negedge clk);
            if (!o_frz) begin
                done = 1'b1;
            end else begin
                check("frozen_wb_ren", {o_wb, o_ren}, 2'b00);
                if (c == 0) begin
                    check("first_cycle_we_n", o_we_n, 1'b1);
                end else begin
                    ehw = (c <= wc) ? v.exp_hw : v.exp_hw + 18'd1;
                    check("sram_we_n_addr", {o_we_n, o_addr}, {~v.w, ehw});
                    if (v.w) check("sram_dq", o_dq, (c <= wc) ? v.st[15:0] : v.st[31:16]);
                end
                n++;
            end
        end
        if (!done) begin
            total++;
            bad++;
            $display("FAIL freeze_timeout: freeze still high after %0d cycles", n);
        end
        check("freeze_cycles", n, v.exp_frz);
        check("done_wb_ren", {o_wb, o_ren}, {v.exp_wb, v.exp_ren});
        check("pass_alu_dest", {o_alu, o_dest}, {v.alu, v.dest});
        check("read_value", o_rd, v.exp_rd);
        if (v.exp_frz != 0) check("done_we_n", o_we_n, 1'b1);
        if (v.w) check("sram_word", mem_word(v.exp_hw), v.st);
        @(posedge clk);
        #1;
    endtask

    vec_t vecs [11];
    vec_t post;

    initial begin
        total = 0; bad = 0;
        sel = 1'b0; wb_in = 1'b0; r_in = 1'b0; w_in = 1'b0;
        alu_in = '0; st_in = '0; dest_in = '0;
        pl_en = 1'b0; pl_addr = '0; pl_data = '0;
        rst = 1'b0;

        //           sel wb r w  alu          st            dest frz hw        ewb eren erd
        vecs[0]  = mk(0, 1, 0, 0, 32'h0000_1234, 32'h0,        4'd5,  0, 18'h0,     1, 0, 32'h0);
        vecs[1]  = mk(0, 0, 0, 1, 32'd1024,      32'hDEAD_BEEF, 4'd0,  5, 18'h0,     0, 0, 32'h0);
        vecs[2]  = mk(0, 1, 1, 0, 32'd1028,      32'h0,        4'd3,  5, 18'h2,     1, 1, 32'h1234_5678);
        vecs[3]  = mk(0, 0, 0, 1, 32'd1040,      32'hCAFE_F00D, 4'd0,  5, 18'h8,     0, 0, 32'h1234_5678);
        vecs[4]  = mk(0, 1, 1, 0, 32'd1040,      32'h0,        4'd7,  5, 18'h8,     1, 1, 32'hCAFE_F00D);
        vecs[5]  = mk(0, 1, 1, 1, 32'd1044,      32'h1111_2222, 4'd2,  5, 18'hA,     1, 1, 32'hCAFE_F00D);
        vecs[6]  = mk(0, 0, 0, 0, 32'hFFFF_0000, 32'h0,        4'd9,  0, 18'h0,     0, 0, 32'hCAFE_F00D);
        vecs[7]  = mk(0, 1, 1, 0, 32'd1044,      32'h0,        4'd1,  5, 18'hA,     1, 1, 32'h1111_2222);
        vecs[8]  = mk(1, 0, 0, 1, 32'd1020,      32'h0BAD_F00D, 4'd0,  3, 18'h3FFFE, 0, 0, 32'h0);
        vecs[9]  = mk(1, 1, 1, 0, 32'd1020,      32'h0,        4'd4,  3, 18'h3FFFE, 1, 1, 32'h0BAD_F00D);
        vecs[10] = mk(1, 1, 0, 0, 32'd1020,      32'h0,        4'd15, 0, 18'h0,     1, 0, 32'h0BAD_F00D);

        #12;
        check("reset_sram_pins", {a_we_n, a_addr, a_dq_out}, {1'b1, 18'h0, 16'h0});
        check("reset_read_value", a_rd, 32'h0);
        check("reset_freeze", a_frz, 1'b0);
`ifdef MEM_STALL_CNT_EN
        check("reset_stall_cnt", a_stall, 32'h0);
`endif
        preload(18'h2, 16'h5678);
        preload(18'h3, 16'h1234);
        @(negedge clk) rst = 1'b1;
        @(posedge clk);
        #1;

        for (int i = 0; i < 11; i++) run_vec(vecs[i]);

        // Store aborted by reset during its HI phase.
        sel = 1'b0; wb_in = 1'b0; r_in = 1'b0; w_in = 1'b1;
        alu_in = 32'd1048; st_in = 32'hA5A5_5A5A; dest_in = 4'd0;
        repeat (3) @(posedge clk);
        #2;
        check("hi_phase_we_n_addr", {a_we_n, a_addr}, {1'b0, 18'd13});
        check("hi_phase_freeze", a_frz, 1'b1);
        rst = 1'b0;
        #1;
        check("abort_we_n", a_we_n, 1'b1);
        check("abort_freeze", a_frz, 1'b0);
        check("abort_addr_dq", {a_addr, a_dq_out}, {18'h0, 16'h0});
        check("abort_read_value", a_rd, 32'h0);
        check("abort_lo_written", {16'h0, mem_a[18'd12]}, 32'h0000_5A5A);
`ifdef MEM_STALL_CNT_EN
        check("abort_stall_cnt", a_stall, 32'h0);
`endif
        w_in = 1'b0;
        @(negedge clk) rst = 1'b1;
        @(posedge clk);
        #1;
        post = mk(0, 1, 1, 0, 32'd1028, 32'h0, 4'd3, 5, 18'h2, 1, 1, 32'h1234_5678);
        run_vec(post);
`ifdef MEM_STALL_CNT_EN
        check("stall_cnt_after_load", a_stall, 32'd5);
`endif
        r_in = 1'b0; wb_in = 1'b0;
        repeat (2) @(posedge clk);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
